// File: rtl/sample_source_if.sv
// sample_source_if
//   Groups the command bus, the collector polling strobe and the ADC
//   handshake of one sample_source_unit.
//   master : collector / command bus / ADC side (drives requests, ADC results)
//   slave  : the sample_source_unit itself
//   Signals:
//     addr[15:0], cmd_data_in[31:0], cs, wr : register write bus
//     output_sample, channel_select[7:0]    : collector fetch strobe and selection
//     sample_data[31:0]                     : presented sample, zero when not selected
//     adc_start / adc_done / adc_data[12:0] : conversion request and result
//     overrun, timeout_err                  : sticky error flags
interface sample_source_if;
    logic [15:0] addr;
    logic [31:0] cmd_data_in;
    logic        cs;
    logic        wr;
    logic        output_sample;
    logic [7:0]  channel_select;
    logic [31:0] sample_data;
    logic        adc_start;
    logic        adc_done;
    logic [12:0] adc_data;
    logic        overrun;
    logic        timeout_err;

    modport master (
        output addr, cmd_data_in, cs, wr, output_sample, channel_select,
        output adc_done, adc_data,
        input  sample_data, adc_start, overrun, timeout_err
    );

    modport slave (
        input  addr, cmd_data_in, cs, wr, output_sample, channel_select,
        input  adc_done, adc_data,
        output sample_data, adc_start, overrun, timeout_err
    );
endinterface

// File: rtl/sample_source_unit.sv
// sample_source_unit
//   One ADC channel responder for the sample collector. Conversions are paced
//   by a programmable divider; the newest result is buffered (pending -> hold)
//   and presented on sample_data while the collector selects POSITION.
//   Unselected units drive zero so outputs can be ORed at the top level.
//
//   Parameters:
//     POSITION    : address high byte and channel id of this unit
//     ADC_TIMEOUT : cycles allowed between adc_start and adc_done
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     bus (slave) : command bus, collector strobe, ADC handshake, error flags
//   Registers (addr[15:8] == POSITION):
//     addr[7:0] == 1 : divider[15:0]
//     addr[7:0] == 5 : command 1=START, 2=STOP, 5=RESET
//
//   Optional feature macro: SAMPLE_STAMP_EN
//     defined   : upper 16 bits of the word carry a per-result counter
//     undefined : upper 16 bits are zero
module sample_source_unit #(
    parameter int unsigned POSITION    = 0,
    parameter int unsigned ADC_TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    sample_source_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        CONVERT   = 2'd2
    } state_t;

    localparam logic [7:0]  POS       = 8'(POSITION);
    localparam logic [15:0] TO_LIM    = 16'(ADC_TIMEOUT);
    localparam logic [31:0] CMD_START = 32'd1;
    localparam logic [31:0] CMD_STOP  = 32'd2;
    localparam logic [31:0] CMD_RESET = 32'd5;

    logic sel_wr;
    logic fetch;
    logic div_wr;
    logic cmd_wr;

    assign sel_wr = bus.cs && bus.wr && (bus.addr[15:8] == POS);
    assign div_wr = sel_wr && (bus.addr[7:0] == 8'd1);
    assign cmd_wr = sel_wr && (bus.addr[7:0] == 8'd5);
    assign fetch  = bus.output_sample && (bus.channel_select == POS);

    state_t      state_q, state_d;
    logic [15:0] divider_q, divider_d;
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        stop_pend_q, stop_pend_d;
    logic [12:0] pending_q, pending_d;
    logic        pending_valid_q, pending_valid_d;
    logic [12:0] hold_q, hold_d;
    logic        adc_start_q, adc_start_d;
    logic        overrun_q, overrun_d;
    logic        timeout_err_q, timeout_err_d;
    logic [31:0] sample_data_q, sample_data_d;

`ifdef SAMPLE_STAMP_EN
    // The stamp travels with its result so the word always pairs a value
    // with the count of the conversion that produced it.
    logic [15:0] stamp_q, stamp_d;
    logic [15:0] pend_stamp_q, pend_stamp_d;
    logic [15:0] hold_stamp_q, hold_stamp_d;
`endif

    logic [15:0] word_stamp;
    logic [31:0] word;
    logic [15:0] reload_val;
    logic        done_ok;
    logic        timeout_hit;

`ifdef SAMPLE_STAMP_EN
    assign word_stamp = hold_stamp_q;
`else
    assign word_stamp = 16'd0;
`endif

    assign word = {word_stamp, 3'b000, hold_q};

    // A zero divider written while running must not wrap to 0xFFFF.
    assign reload_val = (divider_q == 16'd0) ? 16'd0 : (divider_q - 16'd1);

    always_comb begin
        state_d         = state_q;
        divider_d       = divider_q;
        tick_cnt_d      = tick_cnt_q;
        to_cnt_d        = to_cnt_q;
        stop_pend_d     = stop_pend_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        hold_d          = hold_q;
        adc_start_d     = 1'b0;
        overrun_d       = overrun_q;
        timeout_err_d   = timeout_err_q;
        sample_data_d   = fetch ? word : 32'd0;
        done_ok         = 1'b0;
        timeout_hit     = 1'b0;
`ifdef SAMPLE_STAMP_EN
        stamp_d         = stamp_q;
        pend_stamp_d    = pend_stamp_q;
        hold_stamp_d    = hold_stamp_q;
`endif

        // Hold only refreshes outside a fetch, so a word never changes
        // while the collector is reading it.
        if (!fetch) begin
            hold_d          = pending_q;
            pending_valid_d = 1'b0;
`ifdef SAMPLE_STAMP_EN
            hold_stamp_d    = pend_stamp_q;
`endif
        end

        case (state_q)
            WAIT_TICK: begin
                // The reload cycle out of CONVERT counts as the first tick,
                // giving a start-to-start period of divider + ADC latency.
                if (tick_cnt_q <= 16'd1) begin
                    tick_cnt_d  = 16'd0;
                    adc_start_d = 1'b1;
                    to_cnt_d    = 16'd0;
                    state_d     = CONVERT;
                end else begin
                    tick_cnt_d = tick_cnt_q - 16'd1;
                end
            end
            CONVERT: begin
                // A done coinciding with our own start pulse is stale.
                done_ok = bus.adc_done && !adc_start_q;
                if (done_ok) begin
                    pending_d       = bus.adc_data;
                    pending_valid_d = 1'b1;
                    if (pending_valid_q) begin
                        overrun_d = 1'b1;
                    end
`ifdef SAMPLE_STAMP_EN
                    stamp_d      = stamp_q + 16'd1;
                    pend_stamp_d = stamp_q + 16'd1;
`endif
                end else if ((to_cnt_q + 16'd1) >= TO_LIM) begin
                    timeout_hit   = 1'b1;
                    timeout_err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end

                if (done_ok || timeout_hit) begin
                    tick_cnt_d  = reload_val;
                    stop_pend_d = 1'b0;
                    state_d     = stop_pend_q ? IDLE : WAIT_TICK;
                end
            end
            default: begin
            end
        endcase

        if (div_wr) begin
            divider_d = bus.cmd_data_in[15:0];
        end

        // Commands act on the state left by this cycle's ADC handling.
        if (cmd_wr) begin
            case (bus.cmd_data_in)
                CMD_START: begin
                    if (state_d == IDLE && divider_q != 16'd0) begin
                        tick_cnt_d = divider_q - 16'd1;
                        state_d    = WAIT_TICK;
                    end
                end
                CMD_STOP: begin
                    if (state_d == WAIT_TICK) begin
                        state_d = IDLE;
                    end else if (state_d == CONVERT) begin
                        stop_pend_d = 1'b1;
                    end
                end
                CMD_RESET: begin
                    state_d         = IDLE;
                    tick_cnt_d      = 16'd0;
                    to_cnt_d        = 16'd0;
                    stop_pend_d     = 1'b0;
                    pending_d       = 13'd0;
                    pending_valid_d = 1'b0;
                    hold_d          = 13'd0;
                    adc_start_d     = 1'b0;
                    overrun_d       = 1'b0;
                    timeout_err_d   = 1'b0;
                    sample_data_d   = 32'd0;
`ifdef SAMPLE_STAMP_EN
                    stamp_d         = 16'd0;
                    pend_stamp_d    = 16'd0;
                    hold_stamp_d    = 16'd0;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            divider_q       <= 16'd0;
            tick_cnt_q      <= 16'd0;
            to_cnt_q        <= 16'd0;
            stop_pend_q     <= 1'b0;
            pending_q       <= 13'd0;
            pending_valid_q <= 1'b0;
            hold_q          <= 13'd0;
            adc_start_q     <= 1'b0;
            overrun_q       <= 1'b0;
            timeout_err_q   <= 1'b0;
            sample_data_q   <= 32'd0;
`ifdef SAMPLE_STAMP_EN
            stamp_q         <= 16'd0;
            pend_stamp_q    <= 16'd0;
            hold_stamp_q    <= 16'd0;
`endif
        end else begin
            state_q         <= state_d;
            divider_q       <= divider_d;
            tick_cnt_q      <= tick_cnt_d;
            to_cnt_q        <= to_cnt_d;
            stop_pend_q     <= stop_pend_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            hold_q          <= hold_d;
            adc_start_q     <= adc_start_d;
            overrun_q       <= overrun_d;
            timeout_err_q   <= timeout_err_d;
            sample_data_q   <= sample_data_d;
`ifdef SAMPLE_STAMP_EN
            stamp_q         <= stamp_d;
            pend_stamp_q    <= pend_stamp_d;
            hold_stamp_q    <= hold_stamp_d;
`endif
        end
    end

    assign bus.sample_data = sample_data_q;
    assign bus.adc_start   = adc_start_q;
    assign bus.overrun     = overrun_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sample_source_unit.sv
// tb_sample_source_unit
//   Directed bench for sample_source_unit (POSITION=3, ADC_TIMEOUT=255).
//   A small ADC model answers adc_start after adc_lat cycles and timestamps
//   every adc_start pulse and the first timeout_err rise. Expected fetch
//   words go through a scoreboard queue and are popped as sample_data appears.
module tb_sample_source_unit;

    localparam logic [7:0] POS    = 8'd3;
    localparam int         ADC_TO = 255;

    logic clk;
    logic rst;

    sample_source_if bus ();

    sample_source_unit #(
        .POSITION    (POS),
        .ADC_TIMEOUT (ADC_TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests;
    int          fails;
    int          cyc;
    int          start_cnt;
    int          done_cnt;
    int          to_cyc;
    bit          to_seen;
    bit          adc_en;
    int          adc_lat;
    logic [12:0] adc_val;
    int unsigned start_times[$];
    logic [31:0] exp_q[$];

    // ADC model and event recorder; runs 2 time units after each edge so
    // the stimulus (1 unit after the edge) never races with it.
    initial begin : adc_model
        int cnt;
        cnt = 0;
        bus.adc_done = 1'b0;
        bus.adc_data = 13'd0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            bus.adc_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.adc_done = 1'b1;
                    bus.adc_data = adc_val;
                    done_cnt++;
                end
            end
            if (bus.adc_start) begin
                start_times.push_back(cyc);
                start_cnt++;
                if (adc_en) cnt = adc_lat;
            end
            if (bus.timeout_err && !to_seen) begin
                to_seen = 1'b1;
                to_cyc  = cyc;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] expw(input int unsigned n, input logic [12:0] v);
        logic [15:0] s;
        s = 16'(n);
`ifndef SAMPLE_STAMP_EN
        s = 16'h0000;
`endif
        return {s, 3'b000, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic wr_reg(input logic [7:0] pos, input logic [7:0] ra, input logic [31:0] d);
        bus.cs          = 1'b1;
        bus.wr          = 1'b1;
        bus.addr        = {pos, ra};
        bus.cmd_data_in = d;
        step();
        bus.cs          = 1'b0;
        bus.wr          = 1'b0;
        bus.addr        = 16'd0;
        bus.cmd_data_in = 32'd0;
    endtask

    task automatic wait_starts(input int n, input int budget, input string tag);
        int b;
        b = 0;
        while (start_cnt < n && b < budget) begin
            step();
            b++;
        end
        chk(tag, 32'(start_cnt >= n), 32'd1);
    endtask

    task automatic wait_dones(input int n, input int budget, input string tag);
        int b;
        b = 0;
        while (done_cnt < n && b < budget) begin
            step();
            b++;
        end
        chk(tag, 32'(done_cnt >= n), 32'd1);
    endtask

    task automatic wait_timeout(input int budget, input string tag);
        int b;
        b = 0;
        while (!to_seen && b < budget) begin
            step();
            b++;
        end
        chk(tag, 32'(to_seen), 32'd1);
    endtask

    // Selected strobe for n cycles: word expected on each of the n cycles
    // following the rising strobe, then zero once the strobe has dropped.
    task automatic fetch(input int n, input logic [31:0] w, input string tag);
        chk({tag, "_pre"}, bus.sample_data, 32'd0);
        bus.output_sample  = 1'b1;
        bus.channel_select = POS;
        for (int i = 0; i < n; i++) exp_q.push_back(w);
        for (int i = 0; i < n; i++) begin
            step();
            if (i == n - 1) bus.output_sample = 1'b0;
            chk(tag, bus.sample_data, exp_q.pop_front());
        end
        step();
        chk({tag, "_off"}, bus.sample_data, 32'd0);
    endtask

    initial begin : stim
        int res_base;
        int k;
        int n0;
        int n1;
        int n2;
        int n3;
        int d0;
        int c0;
        int unsigned t0;

        tests   = 0;
        fails   = 0;
        adc_en  = 1'b0;
        adc_lat = 3;
        adc_val = 13'd0;
        rst     = 1'b1;
        bus.addr           = 16'd0;
        bus.cmd_data_in    = 32'd0;
        bus.cs             = 1'b0;
        bus.wr             = 1'b0;
        bus.output_sample  = 1'b0;
        bus.channel_select = 8'd0;

        repeat (3) step();
        chk("rst_sample_data", bus.sample_data, 32'd0);
        chk("rst_adc_start", 32'(bus.adc_start), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        chk("rst_timeout", 32'(bus.timeout_err), 32'd0);
        rst = 1'b0;
        step();

        // Divider write to another unit is ignored, so START sees divider 0.
        wr_reg(POS + 8'd1, 8'd1, 32'd4);
        wr_reg(POS, 8'd5, 32'd1);
        repeat (15) step();
        chk("start_div0_ignored", 32'(start_cnt), 32'd0);

        // Normal run: DIV=4, ADC latency 3, value 0x123.
        adc_en   = 1'b1;
        adc_val  = 13'h0123;
        res_base = done_cnt;
        wr_reg(POS, 8'd1, 32'd4);
        wr_reg(POS, 8'd5, 32'd1);
        wait_dones(res_base + 1, 40, "first_done");
        step();
        step();

        bus.output_sample  = 1'b1;
        bus.channel_select = POS + 8'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("unselected_zero", bus.sample_data, 32'd0);
        end
        bus.output_sample = 1'b0;

        fetch(2, expw(1, 13'h0123), "first_fetch");

        wait_starts(3, 40, "third_start");
        chk("start_gap1", start_times[1] - start_times[0], 32'd7);
        chk("start_gap2", start_times[2] - start_times[1], 32'd7);

        // Let conversion 3 land, then switch the ADC value so the next
        // result is distinguishable from the held one.
        wait_dones(done_cnt + 1, 20, "third_done");
        adc_val = 13'h0456;
        k = done_cnt - res_base;
        wait_starts(start_cnt + 1, 20, "fourth_start");
        fetch(4, expw(k, 13'h0123), "fetch_across_done");
        fetch(2, expw(k + 1, 13'h0456), "fetch_new_word");

        // Continuous fetch across two results loses one.
        chk("overrun_pre", 32'(bus.overrun), 32'd0);
        bus.output_sample  = 1'b1;
        bus.channel_select = POS;
        repeat (20) step();
        bus.output_sample = 1'b0;
        step();
        chk("overrun_set", 32'(bus.overrun), 32'd1);

        adc_en = 1'b0;
        rst    = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst2_overrun", 32'(bus.overrun), 32'd0);
        chk("rst2_sample", bus.sample_data, 32'd0);
        repeat (5) step();
        res_base = done_cnt;

        // Timeout: ADC never answers.
        chk("timeout_pre", 32'(bus.timeout_err), 32'd0);
        wr_reg(POS, 8'd1, 32'd4);
        wr_reg(POS, 8'd5, 32'd1);
        n0 = start_cnt;
        wait_starts(n0 + 1, 20, "to_first_start");
        t0 = start_times[n0];
        wait_timeout(300, "timeout_seen");
        chk("timeout_delay", 32'(to_cyc) - t0, 32'(ADC_TO));
        wait_starts(n0 + 2, 300, "to_next_start");
        // Last CONVERT cycle is one before timeout_err appears, then DIV.
        chk("timeout_restart_gap", start_times[n0 + 1] - t0, 32'(ADC_TO - 1 + 4));

        // STOP while converting: result still captured, then idle.
        adc_en  = 1'b1;
        adc_lat = 6;
        adc_val = 13'h0789;
        n1 = start_cnt;
        wait_starts(n1 + 1, 300, "stop_start");
        d0 = done_cnt;
        wr_reg(POS, 8'd5, 32'd2);
        wait_dones(d0 + 1, 20, "stop_done");
        n2 = start_cnt;
        repeat (30) step();
        chk("stop_no_start", 32'(start_cnt), 32'(n2));
        fetch(2, expw(done_cnt - res_base, 13'h0789), "stop_fetch");

        // RESET command clears data but keeps the divider.
        wr_reg(POS, 8'd5, 32'd5);
        step();
        fetch(2, 32'd0, "reset_hold");
        res_base = done_cnt;
        adc_lat  = 3;
        n3 = start_cnt;
        wr_reg(POS, 8'd5, 32'd1);
        c0 = cyc;
        wait_starts(n3 + 1, 20, "div_kept_start");
        chk("div_kept_delay", start_times[n3] - 32'(c0), 32'd4);
        wait_dones(res_base + 1, 20, "after_reset_done");
        step();
        step();
        fetch(2, expw(1, 13'h0789), "after_reset_fetch");
        wr_reg(POS, 8'd5, 32'd2);
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sample_source_unit.md
# sample_source_unit

Conversion-side responder for the sample collector's polling interface. Each instance owns one ADC channel and paces conversions with a programmable divider. It buffers the newest result and presents it on `sample_data` when the collector selects this unit's `POSITION` via `channel_select`/`output_sample`. Instances sit beside the collector; the top level ORs their `sample_data` outputs, since unselected units drive zero.

## Interface
Parameters:
- `POSITION`, 0: command-bus high address byte (`addr[15:8]`) and channel id matched against `channel_select`.
- `ADC_TIMEOUT`, 255: maximum cycles to wait for `adc_done` after `adc_start`.

Ports:
- `clk` in 1: system clock. The block uses this single clock.
- `rst` in 1: reset, synchronous, active-high.
- `addr` in 16: command bus address.
- `cmd_data_in` in 32: command bus write data.
- `cs` in 1: command bus chip select.
- `wr` in 1: command bus write strobe.
- `output_sample` in 1: collector fetch strobe.
- `channel_select` in 8: collector's currently polled unit.
- `sample_data` out 32: presented sample. Zero when this unit is not selected.
- `adc_start` out 1: one-cycle conversion request.
- `adc_done` in 1: conversion complete, one-cycle pulse.
- `adc_data` in 13: conversion result, valid while `adc_done` is high.
- `overrun` out 1: sticky. A result was lost before it reached the hold register.
- `timeout_err` out 1: sticky. `adc_done` did not arrive within `ADC_TIMEOUT` cycles.

## Operation
- Register writes are accepted when `cs & wr & addr[15:8]==POSITION`.
  - `addr[7:0]==1`: `divider[15:0]` is loaded from `cmd_data_in[15:0]`. This sets the conversion period in clk cycles.
  - `addr[7:0]==5`: command. Values 1=START, 2=STOP, 5=RESET; other values are ignored.
- FSM states: `IDLE`, `WAIT_TICK`, `CONVERT`.
  - `IDLE`:
    - On START with `divider!=0`, load `tick_cnt=divider-1` and go to `WAIT_TICK`.
    - START with `divider==0` is ignored.
  - `WAIT_TICK`:
    - Decrement `tick_cnt`.
    - At 0, assert `adc_start` for one cycle, clear `to_cnt`, and go to `CONVERT`.
    - STOP goes to `IDLE`.
  - `CONVERT`:
    - On `adc_done`, latch `adc_data` into `pending`, set `pending_valid`, reload `tick_cnt=divider-1`, and go to `WAIT_TICK`. If STOP was received during `CONVERT`, go to `IDLE` instead.
    - If `to_cnt` reaches `ADC_TIMEOUT`, set `timeout_err` and take the same exit, discarding the result.
- A STOP received in `CONVERT` is remembered (`stop_pend`). The conversion always completes or times out before the block goes idle.
- RESET command has the same effect as `rst`, except that `divider` is preserved.
- A `divider` write while running takes effect at the next reload. It never shortens a countdown already in progress.
- Pending-to-hold transfer:
  - `hold <= pending` and `pending_valid` clears in any cycle where `!(output_sample && channel_select==POSITION)`.
  - `hold` therefore never changes during a fetch.
- Overrun: if `adc_done` arrives while `pending_valid` is still 1, `pending` is overwritten and `overrun` is set.
- Output word is `{stamp[15:0], 3'b000, hold[12:0]}`. `stamp` is defined under Configuration.

## Timing
- Reset values:
  - `sample_data`, `adc_start`, `overrun`, `timeout_err`: 0.
  - Registers: `hold`, `pending`, `divider`, `tick_cnt`, `stamp`: 0.
  - State: `IDLE`.
- `sample_data` is registered:
  - `sample_data <= (output_sample && channel_select==POSITION) ? word : 0`.
  - The word is visible the cycle after each selected strobe cycle. For the collector's two-cycle strobe (fetch, fetch_wait), the word is therefore valid during its store cycle.
  - Output returns to 0 one cycle after the strobe drops or the selection changes.
- Conversion cadence: the cycles between consecutive `adc_start` pulses equal `divider` plus the ADC latency.
  - Minimum `divider=1`: `adc_start` fires in the cycle after entering `WAIT_TICK`.
- `adc_done` in the same cycle as `adc_start` is ignored. Only `adc_done` seen in `CONVERT` counts.
- If a command write coincides with `adc_done`, the `adc_done` is processed first and the command is evaluated against the resulting state in the same cycle.

## Configuration
- `SAMPLE_STAMP_EN` defined:
  - `stamp` is a 16-bit counter, incremented on each result that enters `pending`, wrapping 0xFFFF→0.
  - Repeated identical ADC values therefore produce distinct words, so the collector stores every conversion.
- Not defined:
  - `stamp` is constant 0, occupying no counter logic.
  - Identical consecutive values yield identical words, which the collector discards as unchanged.

## Test plan
- Reset, then DIV=4 and START; ADC answers `adc_done` 3 cycles after `adc_start` with 0x0123:
  - `adc_start` pulses are 7 cycles apart.
  - A fetch after the first result shows 0x0000_0123 (stamp disabled), or 0x0001_0123 (stamp enabled).
- Strobe with `channel_select!=POSITION` → `sample_data` stays 0. Then select POSITION for a 2-cycle strobe → word valid for exactly 2 cycles, starting 1 cycle after the strobe rises.
- Deliver `adc_done` while a 4-cycle selected strobe is active → `sample_data` keeps the old word until the strobe ends, then the new word appears on the next fetch.
- Hold a selected strobe high continuously across two conversions → `overrun` goes to 1. Then `rst` → `overrun` returns to 0.
- Never assert `adc_done` → `timeout_err` is set 255 cycles after `adc_start`, the FSM returns to `WAIT_TICK`, and the next `adc_start` follows DIV cycles later.
- STOP issued mid-`CONVERT`, then `adc_done` → result is captured, the FSM goes to `IDLE`, and no further `adc_start` occurs. RESET command → hold is 0 and divider retains 4.
